// File: rtl/alu_op_sequencer.sv
// Issuing side of the ALU operand/opcode interface: decodes ALUOp/funct, drives
// registered operands to the ALU, then captures and returns the formatted result.
module alu_op_sequencer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_aluop,
   input  logic [5:0]            req_funct,
   input  logic [DATA_WIDTH-1:0] req_a,
   input  logic [DATA_WIDTH-1:0] req_b,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   output logic [2:0]            alu_opcode,
   input  logic [DATA_WIDTH-1:0] alu_out,
   input  logic                  alu_less,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_zero,
   output logic                  rsp_err,
   output logic [CNT_WIDTH-1:0]  ops_done,
   output logic [CNT_WIDTH-1:0]  ops_illegal
);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [2:0]            opc_q, opc_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  zero_q, zero_d;
   logic                  err_q, err_d;
   logic [CNT_WIDTH-1:0]  done_q, done_d;
   logic [CNT_WIDTH-1:0]  ill_q, ill_d;
   logic                  req_ready_q, req_ready_d;
   logic                  rsp_valid_q, rsp_valid_d;

   logic [2:0]            dec_opc;
   logic                  dec_legal;
   logic [DATA_WIDTH-1:0] exec_res;

   // ALUOp/funct to ALU opcode translation
   always_comb begin
      dec_opc   = OP_ADD;
      dec_legal = 1'b1;
      unique case (req_aluop)
         2'b00: dec_opc = OP_ADD;
         2'b01: dec_opc = OP_SUB;
         2'b10: begin
            unique case (req_funct)
               6'b100000: dec_opc = OP_ADD;
               6'b100010: dec_opc = OP_SUB;
               6'b100100: dec_opc = OP_AND;
               6'b100101: dec_opc = OP_OR;
               6'b101010: dec_opc = OP_SLT;
               default:   dec_legal = 1'b0;
            endcase
         end
         default: dec_legal = 1'b0;
      endcase
   end

   // Next-state and datapath updates
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      opc_d    = opc_q;
      data_d   = data_q;
      zero_d   = zero_q;
      err_d    = err_q;
      done_d   = done_q;
      ill_d    = ill_q;
      exec_res = '0;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (dec_legal) begin
                  a_d     = req_a;
                  b_d     = req_b;
                  opc_d   = dec_opc;
                  state_d = EXEC;
               end else begin
                  data_d  = '0;
                  zero_d  = 1'b1;
                  err_d   = 1'b1;
                  state_d = RESP;
               end
            end
         end
         EXEC: begin
            // The ALU leaves out untouched on SLT, so only less is meaningful
            exec_res = (opc_q == OP_SLT) ? DATA_WIDTH'(alu_less) : alu_out;
            data_d   = exec_res;
            zero_d   = (exec_res == '0);
            err_d    = 1'b0;
            state_d  = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
               if (done_q != '1) done_d = done_q + CNT_WIDTH'(1);
               if (err_q && (ill_q != '1)) ill_d = ill_q + CNT_WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         opc_q       <= OP_ADD;
         data_q      <= '0;
         zero_q      <= 1'b0;
         err_q       <= 1'b0;
         done_q      <= '0;
         ill_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         opc_q       <= opc_d;
         data_q      <= data_d;
         zero_q      <= zero_d;
         err_q       <= err_d;
         done_q      <= done_d;
         ill_q       <= ill_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign alu_opcode  = opc_q;
   assign rsp_data    = data_q;
   assign rsp_zero    = zero_q;
   assign rsp_err     = err_q;
   assign ops_done    = done_q;
   assign ops_illegal = ill_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed plus randomized checks of alu_op_sequencer against a behavioural
// ALU and reference model; counters are narrowed so saturation is reachable.
module tb_alu_op_sequencer;

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 2;
   localparam int CNT_MAX = 3;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_aluop;
   logic [5:0]    req_funct;
   logic [DW-1:0] req_a, req_b;
   logic [DW-1:0] alu_a, alu_b;
   logic [2:0]    alu_opcode;
   logic [DW-1:0] alu_out;
   logic          alu_less;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          rsp_zero;
   logic          rsp_err;
   logic [CW-1:0] ops_done;
   logic [CW-1:0] ops_illegal;

   int n_cmp  = 0;
   int n_fail = 0;
   int cycle  = 0;
   int n_done = 0;
   int n_ill  = 0;
   int cyc_accept = 0;
   logic [DW-1:0] last_a   = '0;
   logic [DW-1:0] last_b   = '0;
   logic [2:0]    last_opc = 3'b010;
   logic [DW-1:0] alu_stale = 32'hFFFF_FFFF;

   alu_op_sequencer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_aluop(req_aluop), .req_funct(req_funct),
      .req_a(req_a), .req_b(req_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_out(alu_out), .alu_less(alu_less),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
      .ops_done(ops_done), .ops_illegal(ops_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   // Behavioural ALU: out is not refreshed on SLT, so it shows a stale value
   always_comb begin
      case (alu_opcode)
         3'b010:  alu_out = alu_a + alu_b;
         3'b110:  alu_out = alu_a - alu_b;
         3'b000:  alu_out = alu_a & alu_b;
         3'b001:  alu_out = alu_a | alu_b;
         default: alu_out = alu_stale;
      endcase
      alu_less = ($signed(alu_a) < $signed(alu_b));
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference result {err, data} straight from the instruction semantics
   function automatic logic [DW:0] ref_result(input logic [1:0] op, input logic [5:0] f,
                                              input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW-1:0] lt;
      lt = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      if (op == 2'b00) return {1'b0, a + b};
      if (op == 2'b01) return {1'b0, a - b};
      if (op == 2'b10) begin
         if (f == 6'h20) return {1'b0, a + b};
         if (f == 6'h22) return {1'b0, a - b};
         if (f == 6'h24) return {1'b0, a & b};
         if (f == 6'h25) return {1'b0, a | b};
         if (f == 6'h2A) return {1'b0, lt};
      end
      return {1'b1, 32'd0};
   endfunction

   function automatic logic [2:0] ref_opcode(input logic [1:0] op, input logic [5:0] f);
      if (op == 2'b01) return 3'b110;
      if (op == 2'b10) begin
         if (f == 6'h22) return 3'b110;
         if (f == 6'h24) return 3'b000;
         if (f == 6'h25) return 3'b001;
         if (f == 6'h2A) return 3'b111;
      end
      return 3'b010;
   endfunction

   function automatic int cap(input int n);
      return (n > CNT_MAX) ? CNT_MAX : n;
   endfunction

   task automatic do_op(input logic [1:0] op, input logic [5:0] f,
                        input logic [DW-1:0] a, input logic [DW-1:0] b, input int hold);
      logic [DW:0]   r;
      logic          exp_err;
      logic [DW-1:0] exp_data;
      int            lat;
      r        = ref_result(op, f, a, b);
      exp_err  = r[DW];
      exp_data = r[DW-1:0];
      lat = 0;
      while (!req_ready && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      chk("req_ready_wait", 64'(req_ready), 64'(1));
      req_valid = 1'b1; req_aluop = op; req_funct = f; req_a = a; req_b = b;
      @(posedge clk); #1;
      cyc_accept = cycle;
      req_valid = 1'b0;
      req_aluop = 2'($urandom); req_funct = 6'($urandom);
      req_a = $urandom; req_b = $urandom;
      if (!exp_err) begin
         chk("exec_opcode", 64'(alu_opcode), 64'(ref_opcode(op, f)));
         chk("exec_a", 64'(alu_a), 64'(a));
         chk("exec_b", 64'(alu_b), 64'(b));
      end
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         @(posedge clk); #1; lat++;
      end
      chk("latency", 64'(lat), exp_err ? 64'(1) : 64'(2));
      chk("rsp_data", 64'(rsp_data), 64'(exp_data));
      chk("rsp_zero", 64'(rsp_zero), 64'(exp_data == '0));
      chk("rsp_err", 64'(rsp_err), 64'(exp_err));
      chk("resp_req_ready", 64'(req_ready), 64'(0));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", 64'(rsp_valid), 64'(1));
         chk("hold_req_ready", 64'(req_ready), 64'(0));
         chk("hold_data", 64'(rsp_data), 64'(exp_data));
         chk("hold_err", 64'(rsp_err), 64'(exp_err));
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      n_done++;
      if (exp_err) n_ill++;
      else begin
         last_a = a; last_b = b; last_opc = ref_opcode(op, f);
      end
      chk("post_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("post_req_ready", 64'(req_ready), 64'(1));
      chk("ops_done", 64'(ops_done), 64'(cap(n_done)));
      chk("ops_illegal", 64'(ops_illegal), 64'(cap(n_ill)));
      chk("hold_alu_a", 64'(alu_a), 64'(last_a));
      chk("hold_alu_b", 64'(alu_b), 64'(last_b));
      chk("hold_alu_opcode", 64'(alu_opcode), 64'(last_opc));
   endtask

   initial begin
      logic [5:0] legal_f [5];
      int         prev_accept;
      legal_f = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_aluop = '0; req_funct = '0; req_a = '0; req_b = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_req_ready", 64'(req_ready), 64'(1));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_alu_opcode", 64'(alu_opcode), 64'(3'b010));
      chk("rst_alu_a", 64'(alu_a), 64'(0));
      chk("rst_rsp_data", 64'(rsp_data), 64'(0));
      chk("rst_rsp_zero", 64'(rsp_zero), 64'(0));
      chk("rst_ops_done", 64'(ops_done), 64'(0));

      // Reset asserted while an op is executing
      req_valid = 1'b1; req_aluop = 2'b01; req_funct = 6'h00; req_a = 32'd3; req_b = 32'd4;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("mid_exec_opcode", 64'(alu_opcode), 64'(3'b110));
      #2 rst_n = 1'b0;
      #1;
      chk("async_alu_a", 64'(alu_a), 64'(0));
      chk("async_alu_b", 64'(alu_b), 64'(0));
      chk("async_alu_opcode", 64'(alu_opcode), 64'(3'b010));
      chk("async_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("async_req_ready", 64'(req_ready), 64'(1));
      @(posedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("no_rsp_after_rst", 64'(rsp_valid), 64'(0));
      end
      chk("rst_cnt_done", 64'(ops_done), 64'(0));
      chk("rst_cnt_ill", 64'(ops_illegal), 64'(0));

      do_op(2'b10, 6'h20, 32'd5, 32'd7, 0);                  // ADD
      do_op(2'b10, 6'h00, $urandom, $urandom, 5);            // illegal with backpressure
      do_op(2'b01, 6'h3F, 32'd9, 32'd9, 1);                  // BEQ/SUB
      alu_stale = 32'hFFFF_FFFF;
      do_op(2'b10, 6'h2A, 32'hFFFF_FFFD, 32'd2, 0);          // SLT -3 < 2
      do_op(2'b10, 6'h2A, 32'd4, 32'd2, 2);                  // SLT 4 < 2 with stale out
      do_op(2'b11, 6'h20, 32'd1, 32'd2, 0);                  // reserved aluop
      do_op(2'b00, 6'h2A, 32'h7FFF_FFFF, 32'd1, 0);          // lw/sw add, wraps

      // Back-to-back legal ops with rsp_ready: one accept every 3 cycles
      do_op(2'b10, 6'h24, $urandom, $urandom, 0);
      prev_accept = cyc_accept;
      for (int i = 0; i < 5; i++) begin
         do_op(2'b10, 6'h25, $urandom, $urandom, 0);
         chk("accept_spacing", 64'(cyc_accept - prev_accept), 64'(3));
         prev_accept = cyc_accept;
      end

      for (int i = 0; i < 40; i++) begin
         logic [1:0]    op;
         logic [5:0]    f;
         logic [DW-1:0] a, b;
         op = 2'($urandom);
         f  = ($urandom_range(0, 4) != 0) ? legal_f[$urandom_range(0, 4)] : 6'($urandom);
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
         alu_stale = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
         do_op(op, f, a, b, $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issuing side of the ALU operand/opcode interface.
- Accepts decoded R-type/branch/memory operations from the control path over a valid/ready handshake.
- Translates ALUOp/funct into the 3-bit ALU opcode and drives registered operands to the ALU. It then samples the ALU's out/less and returns a formatted result (including SLT materialisation and a zero flag) over a second valid/ready handshake.
- Sits between the multi-cycle control FSM and the ALU.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match the attached ALU.
- CNT_WIDTH, 16, width of the completed-operation and illegal-operation counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_valid  input  1  operation request valid.
- req_ready  output  1  sequencer can accept a request.
- req_aluop  input  2  00=add (lw/sw), 01=sub (beq), 10=use funct, 11=reserved.
- req_funct  input  6  instruction funct field.
- req_a  input  DATA_WIDTH  rs operand.
- req_b  input  DATA_WIDTH  rt/immediate operand.
- alu_a  output  DATA_WIDTH  registered operand to ALU a.
- alu_b  output  DATA_WIDTH  registered operand to ALU b.
- alu_opcode  output  3  registered opcode to ALU.
- alu_out  input  DATA_WIDTH  ALU result (combinational).
- alu_less  input  1  ALU less flag (combinational).
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  DATA_WIDTH  result.
- rsp_zero  output  1  rsp_data == 0.
- rsp_err  output  1  illegal aluop/funct.
- ops_done  output  CNT_WIDTH  responses accepted, saturating.
- ops_illegal  output  CNT_WIDTH  illegal responses accepted, saturating.

Behaviour:
- Reset (rst_n low, immediate, any state): state=IDLE; alu_a=alu_b=0; alu_opcode=3'b010; rsp_valid=0; rsp_data=0; rsp_zero=0; rsp_err=0; ops_done=ops_illegal=0. Any in-flight operation is discarded with no response.
- States: IDLE, EXEC, RESP.
- req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
- Decode:
  - aluop 00 -> 010.
  - aluop 01 -> 110.
  - aluop 10 with funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other funct, or aluop 11 -> illegal.
- IDLE: on req_valid&&req_ready (edge N):
  - Legal op: load alu_a/alu_b/alu_opcode, go to EXEC.
  - Illegal op: leave ALU registers unchanged; set rsp_data=0, rsp_zero=1, rsp_err=1; go to RESP.
- EXEC (one cycle, ALU settles): at edge N+1 capture the result, then go to RESP.
  - Opcode 111: rsp_data={(DATA_WIDTH-1)'b0, alu_less}; alu_out is ignored (the ALU does not update out on SLT).
  - Otherwise: rsp_data=alu_out.
  - rsp_zero=(captured data==0); rsp_err=0.
- Latency: a legal op has rsp_valid high from the cycle after edge N+1 (2 edges after accept); an illegal op is 1 edge after accept.
- RESP:
  - rsp_data/zero/err are held stable while rsp_valid && !rsp_ready.
  - On rsp_valid&&rsp_ready: go to IDLE, ops_done+=1, and ops_illegal+=1 if rsp_err.
  - Both counters saturate at all-ones (no wrap).
- No request is accepted in the same cycle a response is accepted; req_ready rises the cycle after return to IDLE. Max throughput: one op per 3 cycles.
- alu_a/alu_b/alu_opcode hold their last values outside EXEC; no spurious opcode changes.
- Arithmetic is performed by the ALU, which is signed two's complement; overflow is not flagged and the sequencer passes alu_out through unmodified.
- req_* inputs are sampled only at the accept edge; changes at other times are ignored.

Test Plan:
- Reset: assert rst_n=0 mid-EXEC -> outputs go to reset values immediately, alu_opcode=010, no response appears after release, counters stay 0.
- ADD: aluop=10, funct=100000, a=5, b=7 -> alu_opcode=010 in EXEC; rsp_data=12, rsp_zero=0, rsp_err=0; rsp_valid exactly 2 edges after accept.
- BEQ/SUB: aluop=01, a=9, b=9 -> alu_opcode=110, rsp_data=0, rsp_zero=1.
- SLT: funct=101010 with a=-3, b=2 -> rsp_data=1; with a=4, b=2 -> rsp_data=0, rsp_zero=1, even when alu_out holds stale 0xFFFF_FFFF.
- Backpressure/illegal: funct=000000 with rsp_ready=0 for 5 cycles -> rsp_valid 1 edge after accept, rsp_err=1, data stable and req_ready=0 throughout; after accept ops_done=1, ops_illegal=1, alu_* unchanged.
- Saturation: CNT_WIDTH=2, issue 5 legal ops back-to-back with rsp_ready=1 -> ops_done sticks at 3; each op accepted every 3 cycles.
